// File: rtl/usb_crc_engine_pkg.sv
// Shared constants, packet/state types and the per-byte bit budget for the USB CRC engine.
package usb_crc_engine_pkg;

   localparam logic [4:0]  CRC5_POLY  = 5'h05;
   localparam logic [4:0]  CRC5_INIT  = 5'h1F;
   localparam logic [15:0] CRC16_POLY = 16'h8005;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   localparam logic [2:0] SEL_CRC5  = 3'b001;
   localparam logic [2:0] SEL_CRC16 = 3'b010;
   localparam logic [2:0] SEL_NONE  = 3'b100;

   typedef enum logic [1:0] {
      PKT_TOKEN = 2'b00,
      PKT_DATA  = 2'b01,
      PKT_HS    = 2'b10,
      PKT_RSVD  = 2'b11
   } pkt_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // Tokens carry 11 hashed bits: all of byte 0, then endp[3:1] from byte 1.
   function automatic logic [3:0] nbits_for(input pkt_type_e t, input logic [1:0] tok_cnt);
      case (t)
         PKT_DATA:  return 4'd8;
         PKT_TOKEN: return (tok_cnt == 2'd0) ? 4'd8 : (tok_cnt == 2'd1) ? 4'd3 : 4'd0;
         default:   return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/usb_crc_lfsr.sv
// One-bit combinational step of a Galois-style CRC register, MSB-side feedback.
module usb_crc_lfsr #(
   parameter int           W    = 5,
   parameter logic [W-1:0] POLY = '0
) (
   input  logic [W-1:0] crc_cur,
   input  logic         din,
   output logic [W-1:0] crc_next
);

   logic fb;

   assign fb       = din ^ crc_cur[W-1];
   assign crc_next = {crc_cur[W-2:0], 1'b0} ^ (fb ? POLY : '0);

endmodule

// File: rtl/usb_crc_engine.sv
// Bit-serial CRC5/CRC16 generator for USB token and data packets, feeding crc_mux.
module usb_crc_engine
   import usb_crc_engine_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [1:0]  pkt_type_i,
   input  logic [7:0]  data_i,
   input  logic        data_valid_i,
   output logic        data_ready_o,
   input  logic        end_i,
   output logic [4:0]  crc5_o,
   output logic [15:0] crc16_o,
   output logic [2:0]  sel_o,
   output logic        crc_valid_o,
   output logic        busy_o,
   output logic        err_o
);

   state_e     state, state_nxt;
   pkt_type_e  pkt_q;
   logic [3:0] bit_cnt;
   logic [7:0] sreg;
   logic [1:0] tok_cnt;
   logic       end_pend;
   logic [4:0] c5, c5_nxt, c5_fin;
   logic [15:0] c16, c16_nxt, c16_fin;
   logic [3:0] nbits;
   logic       accept;

   usb_crc_lfsr #(.W(5),  .POLY(CRC5_POLY))  u_lfsr5  (.crc_cur(c5),  .din(sreg[0]), .crc_next(c5_nxt));
   usb_crc_lfsr #(.W(16), .POLY(CRC16_POLY)) u_lfsr16 (.crc_cur(c16), .din(sreg[0]), .crc_next(c16_nxt));

   assign data_ready_o = (state == ST_LOAD) && !end_pend;
   assign accept       = data_valid_i && data_ready_o;
   assign nbits        = nbits_for(pkt_q, tok_cnt);
   assign busy_o       = (state != ST_IDLE);

   // Wire order is crc[0] first, so the complemented register goes out bit-reversed.
   always_comb begin
      c5_fin  = '0;
      c16_fin = '0;
      for (int i = 0; i < 5; i++)  c5_fin[i]  = ~c5[4-i];
      for (int i = 0; i < 16; i++) c16_fin[i] = ~c16[15-i];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD: begin
            if (accept) begin
               if (nbits != 4'd0) state_nxt = ST_SHIFT;
               else if (end_i)    state_nxt = ST_DONE;
            end else if (end_i) begin
               state_nxt = ST_DONE;
            end
         end
         ST_SHIFT: if (bit_cnt == 4'd1) state_nxt = (end_pend || end_i) ? ST_DONE : ST_LOAD;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = state;
      endcase
      // A new start always wins; start with end is an empty packet.
      if (start_i) state_nxt = end_i ? ST_DONE : ST_LOAD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pkt_q       <= PKT_HS;
         bit_cnt     <= '0;
         sreg        <= '0;
         tok_cnt     <= '0;
         end_pend    <= 1'b0;
         c5          <= CRC5_INIT;
         c16         <= CRC16_INIT;
         crc5_o      <= '0;
         crc16_o     <= '0;
         sel_o       <= SEL_NONE;
         crc_valid_o <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         state       <= state_nxt;
         crc_valid_o <= 1'b0;
         if (start_i) begin
            pkt_q    <= pkt_type_e'(pkt_type_i);
            c5       <= CRC5_INIT;
            c16      <= CRC16_INIT;
            tok_cnt  <= '0;
            bit_cnt  <= '0;
            end_pend <= 1'b0;
            err_o    <= 1'b0;
         end else begin
            case (state)
               ST_LOAD: begin
                  if (accept) begin
                     sreg     <= data_i;
                     bit_cnt  <= nbits;
                     end_pend <= end_i;
                     if (pkt_q == PKT_TOKEN) begin
                        if (tok_cnt == 2'd2) err_o <= 1'b1;
                        else                 tok_cnt <= tok_cnt + 2'd1;
                     end
                  end
               end
               ST_SHIFT: begin
                  sreg    <= {1'b0, sreg[7:1]};
                  bit_cnt <= bit_cnt - 4'd1;
                  if (end_i) end_pend <= 1'b1;
                  if (pkt_q == PKT_TOKEN) c5  <= c5_nxt;
                  if (pkt_q == PKT_DATA)  c16 <= c16_nxt;
               end
               ST_DONE: begin
                  end_pend    <= 1'b0;
                  crc_valid_o <= 1'b1;
                  case (pkt_q)
                     PKT_TOKEN: begin crc5_o <= c5_fin; crc16_o <= '0;      sel_o <= SEL_CRC5;  end
                     PKT_DATA:  begin crc5_o <= '0;     crc16_o <= c16_fin; sel_o <= SEL_CRC16; end
                     default:   begin crc5_o <= '0;     crc16_o <= '0;      sel_o <= SEL_NONE;  end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_crc_engine.sv
// Table, hand-sequence and random checks of usb_crc_engine against a reflected-CRC model.
module tb_usb_crc_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  pkt_type_i = 2'b00;
   logic [7:0]  data_i = 8'h00;
   logic        data_valid_i = 1'b0;
   logic        data_ready_o;
   logic        end_i = 1'b0;
   logic [4:0]  crc5_o;
   logic [15:0] crc16_o;
   logic [2:0]  sel_o;
   logic        crc_valid_o;
   logic        busy_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;
   int nvalid = 0;

   usb_crc_engine dut (
      .clk(clk), .rst(rst), .start_i(start_i), .pkt_type_i(pkt_type_i), .data_i(data_i),
      .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .end_i(end_i),
      .crc5_o(crc5_o), .crc16_o(crc16_o), .sel_o(sel_o), .crc_valid_o(crc_valid_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) ncyc++;

   always @(negedge clk) begin
      if (crc_valid_o) nvalid++;
      if (sel_o != 3'b001 && sel_o != 3'b010 && sel_o != 3'b100) begin
         errors++;
         $display("FAIL sel_onehot: got %b, required one-hot", sel_o);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Reflected (LSB-first) formulation; its register is the bit-reverse of the wire-order LFSR.
   function automatic logic [4:0] m5_raw(input logic [15:0] bits, input int nb);
      logic [4:0] r = 5'h1F;
      for (int i = 0; i < nb; i++) r = (r[0] ^ bits[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
      return r;
   endfunction

   function automatic logic [15:0] m16_raw(input logic [7:0][7:0] b, input int n);
      logic [15:0] r = 16'hFFFF;
      for (int k = 0; k < n; k++)
         for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[k][i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return r;
   endfunction

   function automatic int m_nbits(input logic [1:0] t, input int k);
      if (t == 2'b01) return 8;
      if (t == 2'b00) return (k == 0) ? 8 : (k == 1) ? 3 : 0;
      return 0;
   endfunction

   task automatic model(input logic [1:0] t, input logic [7:0][7:0] b, input int n,
                        output logic [4:0] e5, output logic [15:0] e16,
                        output logic [2:0] esel, output logic eerr);
      e5 = '0; e16 = '0; esel = 3'b100; eerr = 1'b0;
      if (t == 2'b00) begin
         e5   = ~m5_raw({5'b0, b[1][2:0], b[0]}, (n >= 2) ? 11 : (n == 1) ? 8 : 0);
         esel = 3'b001;
         eerr = (n > 2);
      end else if (t == 2'b01) begin
         e16  = ~m16_raw(b, n);
         esel = 3'b010;
      end
   endtask

   task automatic wait_ready(input string name);
      int wd = 0;
      while (!data_ready_o && wd < 40) begin @(negedge clk); wd++; end
      if (!data_ready_o) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_pkt(input string name, input logic [1:0] t, input logic [7:0][7:0] b,
                          input int n, input bit early,
                          input logic [4:0] e5, input logic [15:0] e16,
                          input logic [2:0] esel, input logic eerr);
      int last = 0;
      int wd   = 0;
      @(negedge clk);
      start_i = 1'b1; pkt_type_i = t; end_i = (n == 0);
      @(negedge clk);
      start_i = 1'b0; end_i = 1'b0;
      chk({name, "_busy"}, busy_o, 1);
      chk({name, "_err_clr"}, err_o, 0);
      if (n == 0) begin
         @(negedge clk);
         chk({name, "_lat0"}, crc_valid_o, 1);
      end else begin
         for (int k = 0; k < n; k++) begin
            wait_ready(name);
            if (k > 0) chk({name, "_gap"}, ncyc - last, m_nbits(t, k - 1) + 1);
            data_valid_i = 1'b1; data_i = b[k]; last = ncyc;
            @(negedge clk);
            data_valid_i = 1'b0;
         end
         if (early && m_nbits(t, n - 1) > 0) begin
            end_i = 1'b1;
            @(negedge clk);
            end_i = 1'b0;
         end else begin
            wait_ready(name);
            end_i = 1'b1;
            @(negedge clk);
            end_i = 1'b0;
            @(negedge clk);
            chk({name, "_lat"}, crc_valid_o, 1);
         end
      end
      while (!crc_valid_o && wd < 40) begin @(negedge clk); wd++; end
      if (!crc_valid_o) chk({name, "_valid_timeout"}, 32'd0, 32'd1);
      chk({name, "_crc5"}, crc5_o, e5);
      chk({name, "_crc16"}, crc16_o, e16);
      chk({name, "_sel"}, sel_o, esel);
      chk({name, "_err"}, err_o, eerr);
      @(negedge clk);
      chk({name, "_pulse"}, {crc_valid_o, busy_o}, 0);
   endtask

   typedef struct {
      string           name;
      logic [1:0]      t;
      logic [7:0][7:0] b;
      int              n;
      bit              early;
      logic [4:0]      e5;
      logic [15:0]     e16;
      logic [2:0]      esel;
      logic            eerr;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [4:0]      r5, e5;
      logic [15:0]     r16, e16, rev;
      logic [2:0]      esel;
      logic            eerr;
      logic [7:0][7:0] rb;
      int              nv0, n;
      logic [1:0]      t;

      vecs[0] = '{"setup",   2'b00, 64'h0000, 2, 0, 5'h02, 16'h0000, 3'b001, 0};
      vecs[1] = '{"zlp",     2'b01, 64'h0000, 0, 0, 5'h00, 16'h0000, 3'b010, 0};
      vecs[2] = '{"hs",      2'b10, 64'h3C5A, 2, 0, 5'h00, 16'h0000, 3'b100, 0};
      vecs[3] = '{"tok3",    2'b00, 64'h550000, 3, 0, 5'h02, 16'h0000, 3'b001, 1};
      vecs[4] = '{"data4",   2'b01, 64'h03020100, 4, 0, 5'h00, 16'h0000, 3'b010, 0};
      vecs[5] = '{"hs11",    2'b11, 64'h0, 0, 0, 5'h00, 16'h0000, 3'b100, 0};
      vecs[6] = '{"data4e",  2'b01, 64'h03020100, 4, 1, 5'h00, 16'h0000, 3'b010, 0};
      vecs[4].e16 = ~m16_raw(vecs[4].b, 4);
      vecs[6].e16 = vecs[4].e16;

      repeat (3) @(negedge clk);
      chk("rst_ready", data_ready_o, 0);
      chk("rst_out", {crc5_o, crc16_o, sel_o, crc_valid_o, busy_o, err_o}, {5'h0, 16'h0, 3'b100, 3'b000});
      rst = 1'b0;

      foreach (vecs[i])
         run_pkt(vecs[i].name, vecs[i].t, vecs[i].b, vecs[i].n, vecs[i].early,
                 vecs[i].e5, vecs[i].e16, vecs[i].esel, vecs[i].eerr);

      // Residuals: packet bits followed by the emitted CRC bits.
      r5 = m5_raw({5'h02, 11'h000}, 16);
      rev = '0;
      for (int i = 0; i < 5; i++) rev[i] = r5[4-i];
      chk("res5", rev, 16'h000C);
      rb = '0;
      rb[3:0] = 32'h03020100;
      rb[4] = vecs[4].e16[7:0];
      rb[5] = vecs[4].e16[15:8];
      r16 = m16_raw(rb, 6);
      for (int i = 0; i < 16; i++) rev[i] = r16[15-i];
      chk("res16", rev, 16'h800D);

      // Abort a token mid-shift with a data packet.
      nv0 = nvalid;
      @(negedge clk);
      start_i = 1'b1; pkt_type_i = 2'b00;
      @(negedge clk);
      start_i = 1'b0;
      wait_ready("abort");
      data_valid_i = 1'b1; data_i = 8'hA5;
      @(negedge clk);
      data_valid_i = 1'b0;
      rb = 64'hBEEF;
      model(2'b01, rb, 2, e5, e16, esel, eerr);
      run_pkt("abort_data", 2'b01, rb, 2, 0, e5, e16, esel, eerr);
      chk("abort_nvalid", nvalid - nv0, 1);

      // Reset in the middle of a data byte.
      @(negedge clk);
      start_i = 1'b1; pkt_type_i = 2'b01;
      @(negedge clk);
      start_i = 1'b0;
      wait_ready("rst_mid");
      data_valid_i = 1'b1; data_i = 8'hFF;
      @(negedge clk);
      data_valid_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_ready", data_ready_o, 0);
      chk("rst_mid_out", {crc5_o, crc16_o, sel_o, crc_valid_o, busy_o, err_o}, {5'h0, 16'h0, 3'b100, 3'b000});

      for (int p = 0; p < 40; p++) begin
         t = 2'($urandom_range(0, 3));
         n = (t == 2'b01) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
         rb = {$urandom(), $urandom()};
         model(t, rb, n, e5, e16, esel, eerr);
         run_pkt($sformatf("rnd%0d", p), t, rb, n, bit'($urandom_range(0, 1)), e5, e16, esel, eerr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
